uart_baud_gen: RTL and testbench
================================

UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 15_625_000, meaning system clock frequency in Hz (125 MHz / 8).
REQ-002 SHALL have parameter BAUD, default 115200, meaning reset-time baud rate.
REQ-003 SHALL have parameter DIV_W, default 16, meaning integer divisor width.
REQ-004 SHALL have parameter FRAC_W, default 4, meaning fractional divisor width.
REQ-005 SHALL have port clock, input, 1, meaning system clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-007 SHALL have ports cfg_valid (input, 1), cfg_ready (output, 1), cfg_div_int (input, DIV_W) and cfg_div_frac (input, FRAC_W), forming the divisor load handshake.
REQ-008 SHALL have port cfg_err, output, 1, meaning one-cycle pulse when a load is rejected.
REQ-009 SHALL have ports tx_en and rx_en, input, 1 each, meaning channel run enables.
REQ-010 SHALL have port rx_align, input, 1, meaning one-cycle start-edge strobe from the RX front end.
REQ-011 SHALL have ports tx_bit_tick and rx_bit_tick, output, 1 each, meaning one-cycle bit strobes.
REQ-012 SHALL have port busy, output, 1, meaning tx_en | rx_en, registered.

Function
REQ-013 SHALL define the bit period as div_int + div_frac/2^FRAC_W clocks.
REQ-014 SHALL give each channel its own counter (DIV_W bits) and fractional accumulator (FRAC_W bits); the channels are fully independent.
REQ-015 SHALL set the length of bit k to div_int + c_k clocks, where c_k is the carry out of acc + div_frac, computed and stored when tick k-1 fires (for the first bit, when the channel starts).
REQ-016 SHALL start TX at the first edge where tx_en is sampled 1: counter = 0, acc = 0.
REQ-017 SHALL assert tx_bit_tick exactly period_0 cycles after the TX start edge, then once per period.
REQ-018 SHALL, while tx_en = 0, hold TX counter and acc at 0 and keep tx_bit_tick = 0; deasserting tx_en mid-period aborts with no tick.
REQ-019 SHALL ignore rx_align while rx_en = 0 and produce no RX ticks.
REQ-020 SHALL, when rx_align = 1 with rx_en = 1, load the RX counter so that the first rx_bit_tick fires floor(div_int/2) cycles later (mid start bit), clear acc, then tick every period.
REQ-021 SHALL let rx_align during an active RX sequence restart alignment; if it coincides with a tick, the tick is still emitted and alignment wins for the counter.
REQ-022 SHALL hold RX idle after reset or rx_en deassertion until the next rx_align (no free-running ticks).
REQ-023 SHALL drive cfg_ready = ~busy (registered); a load occurs on an edge where cfg_valid & cfg_ready.
REQ-024 SHALL reject any load with cfg_div_int < 2: cfg_err pulses the next cycle and the divisor is unchanged; accepted loads take effect from the next channel start.
REQ-025 SHALL ignore cfg_valid while busy: no error and no change.
REQ-026 SHALL ensure all counter arithmetic saturates nowhere; the counter compares against period-1 and wraps to 0 (or to the RX align value).

Reset
REQ-027 SHALL load the divisor with DEF_INT = CLK_HZ/BAUD (135) and DEF_FRAC = (CLK_HZ*2^FRAC_W/BAUD) mod 2^FRAC_W (10) on reset.
REQ-028 SHALL, on reset, drive tx_bit_tick, rx_bit_tick, cfg_err and busy to 0, cfg_ready to 1, and all counters and accumulators to 0.
REQ-029 SHALL give reset priority over every other input, including mid-period and during a cfg handshake.

Structure
REQ-030 SHALL place DEF_INT/DEF_FRAC computation functions and the min-divisor constant (2) in shared package uart_pkg.
REQ-031 SHALL instantiate sub-module uart_baud_chan twice (TX, RX), with an align/load input; the top holds the divisor registers and the cfg handshake.

Verification
REQ-032 SHALL cover: load int=10, frac=0; raise tx_en at cycle 0 -> tx_bit_tick at cycles 10, 20, 30.
REQ-033 SHALL cover: int=10, frac=8 -> TX periods alternate 10, 11, 10, 11 (ticks at cycles 10, 21, 31, 42).
REQ-034 SHALL cover: rx_en=1, int=10, rx_align at cycle 5 -> rx_bit_tick at cycles 10, 20, 30; a second rx_align at cycle 23 -> next tick at cycle 28.
REQ-035 SHALL cover: cfg_div_int=1 while idle -> cfg_err pulse, and a following TX start still uses period 135.625 (ticks spaced 135/136).
REQ-036 SHALL cover: cfg_valid while tx_en=1 -> cfg_ready=0, no load, no cfg_err; reset at cycle 7 of a period -> no tick, outputs return to reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and reset-divisor helpers for the UART baud generator.
package uart_pkg;

    localparam int unsigned MIN_DIV = 2;

    function automatic int unsigned calc_def_int(
        input longint unsigned clk_hz,
        input longint unsigned baud
    );
        return 32'(clk_hz / baud);
    endfunction

    // Fractional part of clk_hz/baud expressed in 1/2^frac_w steps.
    function automatic int unsigned calc_def_frac(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input int unsigned     frac_w
    );
        return 32'(((clk_hz << frac_w) / baud) % (64'd1 << frac_w));
    endfunction

endpackage

// File: rtl/uart_baud_chan.sv
// One baud channel: integer counter plus fractional accumulator, restartable by load.
module uart_baud_chan #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [DIV_W-1:0]  load_cnt,
    input  logic [FRAC_W-1:0] load_acc,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tick
);

    logic              active;
    logic              carry;
    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [DIV_W-1:0]  div_lat;
    logic [FRAC_W-1:0] frac_lat;

    logic [DIV_W-1:0]  last_c;
    logic              at_end_c;
    logic [FRAC_W:0]   sum_c;

    // Current bit lasts div_lat + carry clocks; counter runs 0..last.
    assign last_c   = div_lat - DIV_W'(1) + DIV_W'(carry);
    assign at_end_c = active && (cnt == last_c);
    assign sum_c    = {1'b0, acc} + {1'b0, frac_lat};

    always_ff @(posedge clock) begin
        if (reset) begin
            active   <= 1'b0;
            carry    <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            div_lat  <= '0;
            frac_lat <= '0;
            tick     <= 1'b0;
        end else if (!en) begin
            active <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            tick   <= 1'b0;
        end else if (load) begin
            // A tick due on this edge is still emitted; the reload wins for the counter.
            active   <= 1'b1;
            carry    <= 1'b0;
            cnt      <= load_cnt;
            acc      <= load_acc;
            div_lat  <= div_int;
            frac_lat <= div_frac;
            tick     <= at_end_c;
        end else if (at_end_c) begin
            tick  <= 1'b1;
            cnt   <= '0;
            carry <= sum_c[FRAC_W];
            acc   <= sum_c[FRAC_W-1:0];
        end else if (active) begin
            tick <= 1'b0;
            cnt  <= cnt + DIV_W'(1);
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Fractional UART baud generator: shared divisor registers with a load
// handshake, driving independent TX and RX bit-tick channels.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 15_625_000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    output logic              cfg_err,
    input  logic              tx_en,
    input  logic              rx_en,
    input  logic              rx_align,
    output logic              tx_bit_tick,
    output logic              rx_bit_tick,
    output logic              busy
);

    localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(calc_def_int(64'(CLK_HZ), 64'(BAUD)));
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(calc_def_frac(64'(CLK_HZ), 64'(BAUD), FRAC_W));

    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              tx_run;

    logic              tx_load_c;
    logic [DIV_W-1:0]  rx_load_cnt_c;

    // TX restarts on every rising tx_en; RX's first tick lands mid start bit.
    assign tx_load_c     = tx_en & ~tx_run;
    assign rx_load_cnt_c = div_int - (div_int >> 1);

    // Divisor registers and load handshake; loads only possible while idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_int   <= DEF_INT;
            div_frac  <= DEF_FRAC;
            tx_run    <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
        end else begin
            tx_run    <= tx_en;
            busy      <= tx_en | rx_en;
            cfg_ready <= ~(tx_en | rx_en);
            cfg_err   <= 1'b0;
            if (cfg_valid && cfg_ready) begin
                if (cfg_div_int < DIV_W'(MIN_DIV)) begin
                    cfg_err <= 1'b1;
                end else begin
                    div_int  <= cfg_div_int;
                    div_frac <= cfg_div_frac;
                end
            end
        end
    end

    uart_baud_chan #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_tx_chan (
        .clock    (clock),
        .reset    (reset),
        .en       (tx_en),
        .load     (tx_load_c),
        .load_cnt ('0),
        .load_acc (div_frac),
        .div_int  (div_int),
        .div_frac (div_frac),
        .tick     (tx_bit_tick)
    );

    uart_baud_chan #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_rx_chan (
        .clock    (clock),
        .reset    (reset),
        .en       (rx_en),
        .load     (rx_align),
        .load_cnt (rx_load_cnt_c),
        .load_acc ('0),
        .div_int  (div_int),
        .div_frac (div_frac),
        .tick     (rx_bit_tick)
    );

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: expected tick/error cycles are queued by stimulus.
module tb_uart_baud_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_div_int = '0;
    logic [3:0]  cfg_div_frac = '0;
    logic        cfg_err;
    logic        tx_en = 1'b0;
    logic        rx_en = 1'b0;
    logic        rx_align = 1'b0;
    logic        tx_bit_tick;
    logic        rx_bit_tick;
    logic        busy;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int txq[$];
    int rxq[$];
    int errq[$];
    int s;

    uart_baud_gen dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_div_int  (cfg_div_int),
        .cfg_div_frac (cfg_div_frac),
        .cfg_err      (cfg_err),
        .tx_en        (tx_en),
        .rx_en        (rx_en),
        .rx_align     (rx_align),
        .tx_bit_tick  (tx_bit_tick),
        .rx_bit_tick  (rx_bit_tick),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the next queued cycle number.
    always @(negedge clock) begin
        int e;
        if (tx_bit_tick === 1'b1) begin
            if (txq.size() == 0) chk("tx_tick_unexpected", cyc, -1);
            else begin e = txq.pop_front(); chk("tx_tick_cycle", cyc, e); end
        end
        if (rx_bit_tick === 1'b1) begin
            if (rxq.size() == 0) chk("rx_tick_unexpected", cyc, -1);
            else begin e = rxq.pop_front(); chk("rx_tick_cycle", cyc, e); end
        end
        if (cfg_err === 1'b1) begin
            if (errq.size() == 0) chk("cfg_err_unexpected", cyc, -1);
            else begin e = errq.pop_front(); chk("cfg_err_cycle", cyc, e); end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic run_until(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
        chk({tag, "_tx_tick"}, int'(tx_bit_tick), 0);
        chk({tag, "_rx_tick"}, int'(rx_bit_tick), 0);
        chk({tag, "_cfg_err"}, int'(cfg_err), 0);
    endtask

    task automatic load_div(input int i, input int f);
        cfg_valid    = 1'b1;
        cfg_div_int  = 16'(i);
        cfg_div_frac = 4'(f);
        if (i < 2) errq.push_back(cyc + 1);
        step(1);
        cfg_valid = 1'b0;
        step(1);
    endtask

    initial begin
        // Reset values
        reset = 1'b1;
        step(3);
        chk_reset_outputs("reset");
        reset = 1'b0;
        step(2);

        // int=10 frac=0: ticks every 10 cycles, disabled mid-period with no tick
        load_div(10, 0);
        s = cyc + 1;
        txq.push_back(s + 10); txq.push_back(s + 20); txq.push_back(s + 30);
        tx_en = 1'b1;
        step(2);
        chk("busy_during_tx", int'(busy), 1);
        chk("ready_during_tx", int'(cfg_ready), 0);
        run_until(s + 35);
        tx_en = 1'b0;
        step(2);
        chk("tx_missing_int10", txq.size(), 0);
        chk("ready_after_tx", int'(cfg_ready), 1);

        // int=10 frac=8: periods 10,11,10,11
        load_div(10, 8);
        s = cyc + 1;
        txq.push_back(s + 10); txq.push_back(s + 21);
        txq.push_back(s + 31); txq.push_back(s + 42);
        tx_en = 1'b1;
        run_until(s + 45);
        tx_en = 1'b0;
        step(2);
        chk("tx_missing_frac8", txq.size(), 0);

        // RX: align ignored while disabled; half-period first tick; realign; align on a tick
        load_div(10, 0);
        rx_align = 1'b1;
        step(1);
        rx_align = 1'b0;
        step(2);
        s = cyc + 1;
        rxq.push_back(s + 10); rxq.push_back(s + 20); rxq.push_back(s + 28);
        rxq.push_back(s + 38); rxq.push_back(s + 43);
        rx_en = 1'b1;
        run_until(s + 4);
        rx_align = 1'b1; step(1); rx_align = 1'b0;
        run_until(s + 22);
        rx_align = 1'b1; step(1); rx_align = 1'b0;
        run_until(s + 37);
        rx_align = 1'b1; step(1); rx_align = 1'b0;
        run_until(s + 45);
        rx_en = 1'b0;
        step(2);
        chk("rx_missing", rxq.size(), 0);

        // Reset restores 135.625; rejected load keeps it
        reset = 1'b1;
        step(2);
        chk_reset_outputs("reset2");
        reset = 1'b0;
        step(1);
        load_div(1, 3);
        step(2);
        chk("cfg_err_missing", errq.size(), 0);
        s = cyc + 1;
        txq.push_back(s + 135); txq.push_back(s + 271);
        txq.push_back(s + 406); txq.push_back(s + 542);
        tx_en = 1'b1;
        run_until(s + 550);
        tx_en = 1'b0;
        step(2);
        chk("tx_missing_default", txq.size(), 0);

        // cfg_valid while busy: no error and no load
        s = cyc + 1;
        tx_en = 1'b1;
        step(2);
        chk("ready_busy_cfg", int'(cfg_ready), 0);
        cfg_valid = 1'b1;
        cfg_div_int = 16'd1;
        step(2);
        chk("err_while_busy", int'(cfg_err), 0);
        cfg_div_int = 16'd20;
        step(2);
        cfg_valid = 1'b0;
        run_until(s + 10);
        tx_en = 1'b0;
        step(2);

        // Divisor unchanged; reset 7 cycles into the second period kills the tick
        s = cyc + 1;
        txq.push_back(s + 135);
        tx_en = 1'b1;
        run_until(s + 141);
        reset = 1'b1;
        step(1);
        chk_reset_outputs("reset_mid");
        step(1);
        reset = 1'b0;
        tx_en = 1'b0;
        step(300);
        chk("tx_missing_final", txq.size(), 0);
        chk("rx_missing_final", rxq.size(), 0);
        chk("err_missing_final", errq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
